fp_operand_pairer: RTL and testbench
====================================

Name: fp_operand_pairer

Overview:
- Upstream feeder for the latency-insensitive FP adder wrapper.
- Accepts a single-word stream of IEEE-754 binary32 values with a packet `last` flag, and emits {a, b} operand pairs over a ready-valid interface.
- Pairing order: first word of a pair → a, second → b.
- An odd-length packet has its final word paired with PAD_VALUE, so pairs never straddle packets.
- A small output FIFO decouples the upstream producer from adder backpressure.

Parameters:
- PAD_VALUE, 32'h0000_0000, b operand used when a packet ends on an unpaired word (+0.0).
- OUT_DEPTH, 2, output FIFO entries; power of two, ≥2.
- CNT_W, 16, width of the statistic counters.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous active-high reset
- word_in  input  32  binary32 operand word
- last_in  input  1  word_in is final word of packet
- valid_in  input  1  word_in/last_in valid
- ready_out  output  1  block accepts a word this cycle
- a  output  32  pair operand a (FIFO head)
- b  output  32  pair operand b (FIFO head)
- last_out  output  1  pair is final pair of packet
- padded_out  output  1  b is PAD_VALUE from padding
- valid_out  output  1  head pair valid
- ready_in  input  1  downstream (adder wrapper) accepts pair
- pair_count  output  CNT_W  pairs emitted (handshaken on output)
- pad_count  output  CNT_W  padded pairs emitted

Behaviour:
- Reset (synchronous, active-high):
  - State → IDLE; held word cleared; FIFO emptied.
  - Counters → 0; a, b, last_out, padded_out, valid_out → 0.
  - ready_out = 0 while reset is high.
- Input accept: `acc = valid_in && ready_out`.
  - ready_out = !reset && (fifo_count < OUT_DEPTH).
  - ready_out is computed from registers only; no combinational path from ready_in or from input data.
- FSM states:
  - IDLE (no held word):
    - acc && !last_in → hold_a <= word_in; go to HOLD_A; no push.
    - acc && last_in → push {word_in, PAD_VALUE, last=1, padded=1}; stay in IDLE.
  - HOLD_A:
    - acc → push {hold_a, word_in, last=last_in, padded=0}; go to IDLE.
- Push guarantee: at most one push per cycle; a push only follows an accepted beat, so the FIFO never overflows.
- Output side:
  - valid_out = (fifo_count != 0).
  - a, b, last_out, padded_out present the head entry.
  - Pop on valid_out && ready_in.
  - When empty, data outputs hold their last driven value; they are 0 after reset.
- Simultaneous push and pop:
  - fifo_count unchanged; both pointers advance.
  - This holds when full too: a pop frees a slot, but ready_out stays 0 that cycle by construction, so no push occurs.
- Head/tail pointers wrap modulo OUT_DEPTH.
- Latency and throughput:
  - A pair is visible on valid_out the cycle after its completing input beat (1-cycle registered latency).
  - Sustained rate: one pair per two input beats.
  - Full rate with downstream always ready.
- Counters:
  - pair_count increments on each output handshake; pad_count on each output handshake where padded_out = 1.
  - Both wrap modulo 2^CNT_W.
- Reset mid-operation: a held a-word and any queued pairs are discarded; no partial pair is emitted afterwards.
- Data is passed bit-exact; NaN/Inf/denormal words are not inspected or altered.

Test Plan:
1. Basic pairing, downstream always ready:
   - Stimulus: words 3F800000, 40000000 (last=0), 40400000, 40800000 (last=1).
   - Required: pairs {3F800000, 40000000, last=0}, {40400000, 40800000, last=1}; pair_count = 2, pad_count = 0.
2. Odd packet:
   - Stimulus: 41200000 (last=0), 41A00000, 41F00000 (last=1).
   - Required: {41200000, 41A00000, last=0}, {41F00000, 00000000, last=1, padded=1}; pad_count = 1.
3. Single-word packet:
   - Stimulus: BF800000 (last=1) from IDLE.
   - Required: one pair {BF800000, 00000000, padded=1}, valid_out the next cycle.
4. Backpressure:
   - Stimulus: ready_in = 0; stream 8 words.
   - Required: ready_out drops after 2 pairs are queued (4 words accepted); no loss.
   - Then ready_in = 1: pairs drain in order; ready_out reasserts the cycle after the first pop.
5. Reset in HOLD_A:
   - Stimulus: send 3F800000 (last=0), assert reset 1 cycle, then send 40000000, 40400000 (last=1).
   - Required: only the pair {40000000, 40400000} appears; counters restart from 0.
6. Counter wrap:
   - Stimulus: CNT_W = 4; emit 17 pairs.
   - Required: pair_count = 1.

Source files
------------

// File: rtl/fp_operand_pairer.sv
// Pairs a stream of binary32 words into {a, b} operand pairs for the FP adder wrapper.
// Odd-length packets pad their final word with PAD_VALUE; a small FIFO absorbs backpressure.
module fp_operand_pairer #(
  parameter logic [31:0] PAD_VALUE = 32'h0000_0000,
  parameter int          OUT_DEPTH = 2,
  parameter int          CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      word_in,
  input  logic             last_in,
  input  logic             valid_in,
  output logic             ready_out,
  output logic [31:0]      a,
  output logic [31:0]      b,
  output logic             last_out,
  output logic             padded_out,
  output logic             valid_out,
  input  logic             ready_in,
  output logic [CNT_W-1:0] pair_count,
  output logic [CNT_W-1:0] pad_count
);

  localparam int                PTR_W   = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
  localparam int                FCNT_W  = $clog2(OUT_DEPTH) + 1;
  localparam logic [FCNT_W-1:0] DEPTH_C = FCNT_W'(OUT_DEPTH);

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic        last;
    logic        padded;
  } pair_t;

  typedef enum logic {IDLE, HOLD_A} state_t;

  state_t            state_q, state_d;
  logic [31:0]       hold_q, hold_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [FCNT_W-1:0] fcnt_q, fcnt_d;
  logic [CNT_W-1:0]  pair_cnt_q, pair_cnt_d;
  logic [CNT_W-1:0]  pad_cnt_q, pad_cnt_d;
  pair_t             shown_q, shown_d;
  pair_t             mem_q [OUT_DEPTH];

  logic  acc;
  logic  push;
  logic  pop;
  pair_t push_entry;
  pair_t head;
  pair_t out_pair;

  // ready_out depends only on registered occupancy (and reset), never on ready_in
  assign ready_out = !reset && (fcnt_q < DEPTH_C);
  assign acc       = valid_in && ready_out;
  assign valid_out = (fcnt_q != '0);
  assign head      = mem_q[rd_ptr_q];
  assign pop       = valid_out && ready_in;

  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    push       = 1'b0;
    push_entry = '0;
    case (state_q)
      IDLE: begin
        if (acc) begin
          if (last_in) begin
            push       = 1'b1;
            push_entry = '{a: word_in, b: PAD_VALUE, last: 1'b1, padded: 1'b1};
          end else begin
            hold_d  = word_in;
            state_d = HOLD_A;
          end
        end
      end
      HOLD_A: begin
        if (acc) begin
          push       = 1'b1;
          push_entry = '{a: hold_q, b: word_in, last: last_in, padded: 1'b0};
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d   = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    fcnt_d     = fcnt_q;
    if (push && !pop) fcnt_d = fcnt_q + 1'b1;
    if (!push && pop) fcnt_d = fcnt_q - 1'b1;
    pair_cnt_d = pop ? pair_cnt_q + 1'b1 : pair_cnt_q;
    pad_cnt_d  = (pop && head.padded) ? pad_cnt_q + 1'b1 : pad_cnt_q;
    // Remember the pair just handed off so the outputs hold it while empty
    shown_d    = pop ? head : shown_q;
  end

  assign out_pair   = valid_out ? head : shown_q;
  assign a          = out_pair.a;
  assign b          = out_pair.b;
  assign last_out   = out_pair.last;
  assign padded_out = out_pair.padded;
  assign pair_count = pair_cnt_q;
  assign pad_count  = pad_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      hold_q     <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fcnt_q     <= '0;
      pair_cnt_q <= '0;
      pad_cnt_q  <= '0;
      shown_q    <= '0;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fcnt_q     <= fcnt_d;
      pair_cnt_q <= pair_cnt_d;
      pad_cnt_q  <= pad_cnt_d;
      shown_q    <= shown_d;
    end
  end

  // FIFO storage needs no reset: entries are only read while fcnt_q says they are live
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_entry;
  end

endmodule

// File: tb/tb_fp_operand_pairer.sv
// Bench for fp_operand_pairer: directed packets plus random traffic, compared every
// cycle against a queue-based model of the pair stream.
module tb_fp_operand_pairer;

  localparam int          DEPTH = 2;
  localparam int          CW    = 4;
  localparam logic [31:0] PAD   = 32'h0000_0000;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [31:0]   word_in = '0;
  logic          last_in = 1'b0;
  logic          valid_in = 1'b0;
  logic          ready_out;
  logic [31:0]   a, b;
  logic          last_out, padded_out, valid_out;
  logic          ready_in = 1'b1;
  logic [CW-1:0] pair_count, pad_count;

  fp_operand_pairer #(.PAD_VALUE(PAD), .OUT_DEPTH(DEPTH), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .word_in(word_in), .last_in(last_in), .valid_in(valid_in),
    .ready_out(ready_out), .a(a), .b(b), .last_out(last_out), .padded_out(padded_out),
    .valid_out(valid_out), .ready_in(ready_in), .pair_count(pair_count), .pad_count(pad_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        last;
    logic        padded;
  } pair_t;

  pair_t         q[$];
  pair_t         shown;
  bit            have_hold;
  logic [31:0]   held;
  logic [CW-1:0] m_pairs, m_pads;
  bit            accepted;
  int            total = 0;
  int            bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    have_hold = 0;
    held      = '0;
    m_pairs   = '0;
    m_pads    = '0;
    shown     = '{a: '0, b: '0, last: 1'b0, padded: 1'b0};
  endtask

  // Check outputs mid-cycle, then advance the model across the next rising edge
  task automatic tick();
    bit    acc, pop;
    pair_t exp;
    @(negedge clk);
    chk("valid_out", 32'(valid_out), 32'(q.size() != 0));
    chk("ready_out", 32'(ready_out), 32'(!reset && q.size() < DEPTH));
    exp = (q.size() != 0) ? q[0] : shown;
    chk("a", a, exp.a);
    chk("b", b, exp.b);
    chk("last_out", 32'(last_out), 32'(exp.last));
    chk("padded_out", 32'(padded_out), 32'(exp.padded));
    chk("pair_count", 32'(pair_count), 32'(m_pairs));
    chk("pad_count", 32'(pad_count), 32'(m_pads));
    acc      = valid_in && !reset && (q.size() < DEPTH);
    pop      = (q.size() != 0) && ready_in;
    accepted = acc;
    @(posedge clk);
    if (reset) begin
      model_reset();
    end else begin
      if (pop) begin
        shown = q.pop_front();
        m_pairs++;
        if (shown.padded) m_pads++;
      end
      if (acc) begin
        if (have_hold) begin
          q.push_back('{a: held, b: word_in, last: last_in, padded: 1'b0});
          have_hold = 0;
        end else if (last_in) begin
          q.push_back('{a: word_in, b: PAD, last: 1'b1, padded: 1'b1});
        end else begin
          held      = word_in;
          have_hold = 1;
        end
      end
    end
    #1;
  endtask

  task automatic send_word(input logic [31:0] w, input logic l);
    int n = 0;
    word_in  = w;
    last_in  = l;
    valid_in = 1'b1;
    do begin
      tick();
      n++;
    end while (!accepted && n < 50);
    chk("send_timeout", 32'(accepted), 32'd1);
    valid_in = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    ready_in = 1'b1;
    while (q.size() != 0 && n < 50) begin
      tick();
      n++;
    end
    chk("drain_timeout", 32'(q.size()), 32'd0);
    tick();
  endtask

  initial begin
    model_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();

    // Basic pairing
    send_word(32'h3F800000, 1'b0);
    send_word(32'h40000000, 1'b0);
    send_word(32'h40400000, 1'b0);
    send_word(32'h40800000, 1'b1);
    drain();
    chk("t1_pairs", 32'(pair_count), 32'd2);
    chk("t1_pads", 32'(pad_count), 32'd0);

    // Odd packet
    send_word(32'h41200000, 1'b0);
    send_word(32'h41A00000, 1'b0);
    send_word(32'h41F00000, 1'b1);
    drain();
    chk("t2_pads", 32'(pad_count), 32'd1);

    // Single-word packet, visible the next cycle
    send_word(32'hBF800000, 1'b1);
    @(negedge clk);
    chk("t3_valid", 32'(valid_out), 32'd1);
    chk("t3_a", a, 32'hBF800000);
    chk("t3_b", b, 32'h00000000);
    chk("t3_padded", 32'(padded_out), 32'd1);
    #1;
    @(posedge clk);
    shown = q.pop_front();
    m_pairs++;
    m_pads++;
    #1;
    drain();

    // Backpressure: four words fill the FIFO, fifth stalls
    ready_in = 1'b0;
    for (int i = 0; i < 4; i++) send_word(32'h42000000 + 32'(i), 1'(i == 3));
    word_in  = 32'h42000004;
    last_in  = 1'b0;
    valid_in = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    chk("t4_stall_ready", 32'(ready_out), 32'd0);
    ready_in = 1'b1;
    for (int i = 4; i < 8; i++) send_word(32'h42000000 + 32'(i), 1'(i == 7));
    drain();

    // Reset while holding an a-word
    send_word(32'h3F800000, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t5_cnt_cleared", 32'(pair_count), 32'd0);
    send_word(32'h40000000, 1'b0);
    send_word(32'h40400000, 1'b1);
    tick();
    chk("t5_a", a, 32'h40000000);
    chk("t5_b", b, 32'h40400000);
    drain();
    chk("t5_pairs", 32'(pair_count), 32'd1);

    // Counter wrap at CNT_W = 4
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 17; i++) send_word(32'h7FC00000 + 32'(i), 1'b1);
    drain();
    chk("t6_pair_wrap", 32'(pair_count), 32'd1);
    chk("t6_pad_wrap", 32'(pad_count), 32'd1);

    // Random traffic with random backpressure and input gaps
    for (int i = 0; i < 300; i++) begin
      ready_in = 1'($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 3) == 0) begin
        valid_in = 1'b0;
        tick();
      end else begin
        word_in  = $urandom;
        last_in  = 1'($urandom_range(0, 2) == 0);
        valid_in = 1'b1;
        tick();
        valid_in = 1'b0;
      end
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
